// File: rtl/seg7_to_hex.sv
// Seven-segment pattern receiver: synchronizes asynchronous segment levels,
// filters them for stability and decodes accepted patterns back to a hex digit.
module seg7_to_hex #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   input  logic       dp_in,
   input  logic       clr_err,
   output logic [3:0] digit,
   output logic       dp_out,
   output logic       valid,
   output logic       blank,
   output logic       err,
   output logic       update,
   output logic [7:0] err_count
);

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   // Held classification of the last accepted pattern; NONE only until the first acceptance.
   typedef enum logic [1:0] {
      CLS_NONE  = 2'd0,
      CLS_VALID = 2'd1,
      CLS_BLANK = 2'd2,
      CLS_ERR   = 2'd3
   } cls_e;

   logic [7:0] sync1_q, sync2_q;
   logic [7:0] cand_q, cand_d;
   logic [7:0] cnt_q, cnt_d;
   logic       acc_q, acc_d;
   cls_e       cls_q, cls_d;
   logic [3:0] digit_q, digit_d;
   logic       dp_q, dp_d;
   logic       update_q, update_d;
   logic [7:0] err_count_q, err_count_d;
   logic       accept;
   logic [4:0] dec;

   // Returns {hit, value}; hit=0 for any pattern outside the table (including all-off).
   function automatic logic [4:0] decode(input logic [6:0] seg);
      logic [4:0] r;
      r = 5'h00;
      case (seg)
         7'h3F: r = {1'b1, 4'h0};
         7'h06: r = {1'b1, 4'h1};
         7'h5B: r = {1'b1, 4'h2};
         7'h4F: r = {1'b1, 4'h3};
         7'h66: r = {1'b1, 4'h4};
         7'h6D: r = {1'b1, 4'h5};
         7'h7D: r = {1'b1, 4'h6};
         7'h07: r = {1'b1, 4'h7};
         7'h27: r = {1'b1, 4'h7};
         7'h7F: r = {1'b1, 4'h8};
         7'h6F: r = {1'b1, 4'h9};
         7'h67: r = {1'b1, 4'h9};
         7'h77: r = {1'b1, 4'hA};
         7'h7C: r = {1'b1, 4'hB};
         7'h39: r = {1'b1, 4'hC};
         7'h5E: r = {1'b1, 4'hD};
         7'h79: r = {1'b1, 4'hE};
         7'h71: r = {1'b1, 4'hF};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 8'h00;
         sync2_q     <= 8'h00;
         cand_q      <= 8'h00;
         cnt_q       <= 8'h00;
         acc_q       <= 1'b0;
         cls_q       <= CLS_NONE;
         digit_q     <= 4'h0;
         dp_q        <= 1'b0;
         update_q    <= 1'b0;
         err_count_q <= 8'h00;
      end else begin
         sync1_q     <= {dp_in, seg_in};
         sync2_q     <= sync1_q;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         cls_q       <= cls_d;
         digit_q     <= digit_d;
         dp_q        <= dp_d;
         update_q    <= update_d;
         err_count_q <= err_count_d;
      end
   end

   always_comb begin
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      cls_d       = cls_q;
      digit_d     = digit_q;
      dp_d        = dp_q;
      update_d    = 1'b0;
      err_count_d = err_count_q;
      accept      = 1'b0;
      dec         = decode(cand_q[6:0]);

      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = 8'h00;
         acc_d  = 1'b0;
      end else if (!acc_q && (cnt_q == CNT_LAST)) begin
         accept = 1'b1;
         acc_d  = 1'b1;
      end else if (!acc_q) begin
         cnt_d = cnt_q + 8'd1;
      end

      if (accept) begin
         dp_d = cand_q[7];
         if (cand_q[6:0] == 7'h00) begin
            cls_d = CLS_BLANK;
         end else if (dec[4]) begin
            cls_d   = CLS_VALID;
            digit_d = dec[3:0];
         end else begin
            cls_d = CLS_ERR;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
         end
         update_d = (cls_d != cls_q) || (digit_d != digit_q) || (dp_d != dp_q);
      end

      if (clr_err) err_count_d = 8'h00;
   end

   assign digit     = digit_q;
   assign dp_out    = dp_q;
   assign valid     = (cls_q == CLS_VALID);
   assign blank     = (cls_q == CLS_BLANK);
   assign err       = (cls_q == CLS_ERR);
   assign update    = update_q;
   assign err_count = err_count_q;

endmodule
